// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcode, state and key encodings for the calculator sequencer
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_SHL = 3'b110,
        OP_ASR = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        SHOW    = 3'd4
    } state_e;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/calc_digit_accum.sv
// rtl/calc_digit_accum.sv - combinational acc*10+digit with overflow/bad-digit reject
module calc_digit_accum
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] acc_next,
    output logic             reject
);

    logic [WIDTH+3:0] acc_w;
    logic [WIDTH+3:0] wide;

    // Four guard bits hold acc*10+9 for any acc, so overflow is just a non-zero top nibble.
    assign acc_w    = {4'b0000, acc};
    assign wide     = (acc_w << 3) + (acc_w << 1) + {{WIDTH{1'b0}}, digit};
    assign reject   = (digit > DIGIT_MAX) || (wide[WIDTH+3:WIDTH] != 4'b0000);
    assign acc_next = reject ? acc : wide[WIDTH-1:0];

endmodule

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - key-entry sequencer feeding the AU; optional result chaining via CALC_CHAIN_EN
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             op_valid,
    input  logic [2:0]       op_sel,
    input  logic             eq_valid,
    input  logic             clr_valid,
    input  logic             au_done,
    input  logic [WIDTH-1:0] au_result,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [2:0]       op,
    output logic             start,
    output logic [WIDTH-1:0] display,
    output logic             busy,
    output logic             error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e           state, state_next;
    logic [WIDTH-1:0] a_next, b_next, display_next;
    logic [2:0]       op_next;
    logic             error_next;
    logic [CW-1:0]    cnt, cnt_next;

    logic             key_clr, key_eq, key_op, key_dig;
    logic [WIDTH-1:0] acc_in, acc_out;
    logic             acc_reject;

    // Same-cycle strobes resolve as clr > eq > op > digit; losers are dropped.
    assign key_clr = clr_valid;
    assign key_eq  = eq_valid & ~clr_valid;
    assign key_op  = op_valid & ~eq_valid & ~clr_valid;
    assign key_dig = digit_valid & ~op_valid & ~eq_valid & ~clr_valid;

    // The single accumulator serves whichever operand is being typed; SHOW starts a fresh A.
    always_comb begin
        acc_in = a;
        case (state)
            ENTER_B: acc_in = b;
            SHOW:    acc_in = '0;
            default: acc_in = a;
        endcase
    end

    calc_digit_accum #(
        .WIDTH(WIDTH)
    ) u_accum (
        .acc     (acc_in),
        .digit   (digit),
        .acc_next(acc_out),
        .reject  (acc_reject)
    );

    // State and datapath registers; everything returns to the entry-ready idle on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ENTER_A;
            a       <= '0;
            b       <= '0;
            op      <= 3'b000;
            display <= '0;
            error   <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_next;
            a       <= a_next;
            b       <= b_next;
            op      <= op_next;
            display <= display_next;
            error   <= error_next;
            cnt     <= cnt_next;
        end
    end

    // Next-state and output decode; a/b/op are only written in the entry states and SHOW,
    // so they stay frozen for the AU from ISSUE through WAIT.
    always_comb begin
        state_next   = state;
        a_next       = a;
        b_next       = b;
        op_next      = op;
        display_next = display;
        error_next   = error;
        cnt_next     = cnt;
        start        = 1'b0;
        busy         = 1'b0;

        case (state)
            ISSUE: begin
                start = 1'b1;
                busy  = 1'b1;
            end
            WAIT: begin
                busy = 1'b1;
            end
            default: begin
            end
        endcase

        if (key_clr) begin
            state_next   = ENTER_A;
            a_next       = '0;
            b_next       = '0;
            op_next      = 3'b000;
            display_next = '0;
            error_next   = 1'b0;
            cnt_next     = '0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (key_op) begin
                        op_next    = op_sel;
                        b_next     = '0;
                        state_next = ENTER_B;
                    end else if (key_dig && !acc_reject) begin
                        a_next       = acc_out;
                        display_next = acc_out;
                    end
                end
                ENTER_B: begin
                    if (key_eq) begin
                        if (op == OP_DIV && b == '0) begin
                            error_next   = 1'b1;
                            display_next = '0;
                            state_next   = SHOW;
                        end else begin
                            state_next = ISSUE;
                        end
                    end else if (key_op) begin
                        op_next = op_sel;
                    end else if (key_dig && !acc_reject) begin
                        b_next       = acc_out;
                        display_next = acc_out;
                    end
                end
                ISSUE: begin
                    cnt_next   = '0;
                    state_next = WAIT;
                end
                WAIT: begin
                    if (au_done) begin
                        display_next = au_result;
                        state_next   = SHOW;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        error_next   = 1'b1;
                        display_next = '0;
                        state_next   = SHOW;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (key_op) begin
`ifdef CALC_CHAIN_EN
                        if (!error) begin
                            a_next     = display;
                            op_next    = op_sel;
                            b_next     = '0;
                            state_next = ENTER_B;
                        end
`else
                        state_next = SHOW;
`endif
                    end else if (key_dig && !acc_reject) begin
                        a_next       = acc_out;
                        b_next       = '0;
                        display_next = acc_out;
                        state_next   = ENTER_A;
                    end
                end
                default: begin
                    state_next = ENTER_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - randomized + directed self-checking bench for calc_op_sequencer
module tb_calc_op_sequencer;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 255;
    localparam int MAXV    = (1 << WIDTH) - 1;

    localparam int MD_A = 0, MD_B = 1, MD_ISSUE = 2, MD_WAIT = 3, MD_SHOW = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             digit_valid = 1'b0;
    logic [3:0]       digit = 4'd0;
    logic             op_valid = 1'b0;
    logic [2:0]       op_sel = 3'd0;
    logic             eq_valid = 1'b0;
    logic             clr_valid = 1'b0;
    logic             au_done = 1'b0;
    logic [WIDTH-1:0] au_result = '0;
    logic [WIDTH-1:0] a, b, display;
    logic [2:0]       op;
    logic             start, busy, error;

    int nvec = 0;
    int nmis = 0;
    int n_start = 0;

    int m_mode, m_a, m_b, m_op, m_disp, m_err, m_cnt;
    int n_mode, n_a, n_b, n_op, n_disp, n_err, n_cnt;

    calc_op_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
        .op_valid(op_valid), .op_sel(op_sel), .eq_valid(eq_valid), .clr_valid(clr_valid),
        .au_done(au_done), .au_result(au_result), .a(a), .b(b), .op(op), .start(start),
        .display(display), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_zero();
        n_mode = MD_A; n_a = 0; n_b = 0; n_op = 0; n_disp = 0; n_err = 0; n_cnt = 0;
    endtask

    // Calculator behaviour from the key-level rules, evaluated on the inputs present this cycle.
    task automatic model_step();
        bit k_eq, k_op, k_dig;
        int v, acc;
        n_mode = m_mode; n_a = m_a; n_b = m_b; n_op = m_op;
        n_disp = m_disp; n_err = m_err; n_cnt = m_cnt;
        k_eq  = eq_valid;
        k_op  = op_valid && !eq_valid;
        k_dig = digit_valid && !op_valid && !eq_valid && (int'(digit) <= 9);
        if (reset || clr_valid) begin
            model_zero();
        end else begin
            case (m_mode)
                MD_A: begin
                    if (k_op) begin
                        n_op = int'(op_sel); n_b = 0; n_mode = MD_B;
                    end else if (k_dig) begin
                        v = m_a * 10 + int'(digit);
                        if (v <= MAXV) begin n_a = v; n_disp = v; end
                    end
                end
                MD_B: begin
                    if (k_eq) begin
                        if (m_op == 3 && m_b == 0) begin
                            n_err = 1; n_disp = 0; n_mode = MD_SHOW;
                        end else begin
                            n_mode = MD_ISSUE;
                        end
                    end else if (k_op) begin
                        n_op = int'(op_sel);
                    end else if (k_dig) begin
                        v = m_b * 10 + int'(digit);
                        if (v <= MAXV) begin n_b = v; n_disp = v; end
                    end
                end
                MD_ISSUE: begin
                    n_cnt = 0; n_mode = MD_WAIT;
                end
                MD_WAIT: begin
                    if (au_done) begin
                        n_disp = int'(au_result); n_mode = MD_SHOW;
                    end else if (m_cnt == TIMEOUT) begin
                        n_err = 1; n_disp = 0; n_mode = MD_SHOW;
                    end else begin
                        n_cnt = m_cnt + 1;
                    end
                end
                default: begin
                    if (k_op) begin
`ifdef CALC_CHAIN_EN
                        if (m_err == 0) begin
                            acc = m_disp;
                            n_a = acc; n_op = int'(op_sel); n_b = 0; n_mode = MD_B;
                        end
`endif
                    end else if (k_dig) begin
                        n_a = int'(digit); n_b = 0; n_disp = int'(digit); n_mode = MD_A;
                    end
                end
            endcase
        end
    endtask

    task automatic commit();
        m_mode = n_mode; m_a = n_a; m_b = n_b; m_op = n_op;
        m_disp = n_disp; m_err = n_err; m_cnt = n_cnt;
    endtask

    task automatic check_all();
        chk("a", int'(a), m_a);
        chk("b", int'(b), m_b);
        chk("op", int'(op), m_op);
        chk("display", int'(display), m_disp);
        chk("error", int'(error), m_err);
        chk("start", int'(start), (m_mode == MD_ISSUE) ? 1 : 0);
        chk("busy", int'(busy), (m_mode == MD_ISSUE || m_mode == MD_WAIT) ? 1 : 0);
    endtask

    // One clock: predict, advance, compare every output, then drop all strobes.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        commit();
        check_all();
        if (start) n_start++;
        digit_valid = 1'b0; op_valid = 1'b0; eq_valid = 1'b0; clr_valid = 1'b0;
        au_done = 1'b0;
    endtask

    task automatic press_digit(input int d);
        digit_valid = 1'b1; digit = 4'(d); cycle();
    endtask

    task automatic press_op(input int o);
        op_valid = 1'b1; op_sel = 3'(o); cycle();
    endtask

    task automatic press_eq();
        eq_valid = 1'b1; cycle();
    endtask

    task automatic press_clr();
        clr_valid = 1'b1; cycle();
    endtask

    initial begin
        int n_busy;
        model_zero();
        commit();

        // Reset state
        cycle();
        cycle();
        reset = 1'b0;
        chk("reset_display", int'(display), 0);
        chk("reset_busy", int'(busy), 0);

        // 12 + 3 = 15, done two cycles after start
        n_start = 0;
        press_digit(1); press_digit(2); press_op(0); press_digit(3); press_eq();
        cycle();
        au_done = 1'b1; au_result = 8'd15; cycle();
        cycle();
        chk("t1_a", int'(a), 12);
        chk("t1_b", int'(b), 3);
        chk("t1_op", int'(op), 0);
        chk("t1_display", int'(display), 15);
        chk("t1_start_pulses", n_start, 1);

        // Operator key in SHOW: chaining or ignored
        press_op(1);
        chk("t6_display_after_op", int'(display), 15);
`ifdef CALC_CHAIN_EN
        chk("t6_a_after_op", int'(a), 15);
`else
        chk("t6_a_after_op", int'(a), 12);
`endif
        press_digit(5); press_eq();
`ifdef CALC_CHAIN_EN
        chk("t6_chain_a", int'(a), 15);
        chk("t6_chain_b", int'(b), 5);
        chk("t6_chain_op", int'(op), 1);
        chk("t6_chain_start", int'(start), 1);
`else
        chk("t6_nochain_a", int'(a), 5);
`endif
        press_clr();

        // Overflow rejection at WIDTH=8
        press_digit(2); press_digit(5); press_digit(5); press_digit(9);
        chk("t2_a_255", int'(a), 255);
        chk("t2_disp_255", int'(display), 255);
        press_clr();
        press_digit(2); press_digit(5); press_digit(6);
        chk("t2_a_25", int'(a), 25);
        chk("t2_disp_25", int'(display), 25);
        press_clr();

        // Divide by zero
        n_start = 0;
        press_digit(1); press_op(3); press_eq(); cycle();
        chk("t3_error", int'(error), 1);
        chk("t3_no_start", n_start, 0);
        chk("t3_busy", int'(busy), 0);
        press_op(0);
        chk("t3_op_ignored_display", int'(display), 0);
        press_clr();
        chk("t3_clr_error", int'(error), 0);
        chk("t3_clr_display", int'(display), 0);

        // Timeout with au_done held low
        press_digit(4); press_op(2); press_digit(6); press_eq();
        n_busy = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            n_busy++;
            cycle();
        end
        chk("t4_busy_cycles", n_busy, TIMEOUT + 2);
        chk("t4_error", int'(error), 1);
        chk("t4_display", int'(display), 0);
        press_clr();

        // clr in WAIT, then a late au_done
        press_digit(9); press_op(0); press_digit(1); press_eq(); cycle();
        press_clr();
        au_done = 1'b1; au_result = 8'd99; cycle();
        chk("t5_late_done_display", int'(display), 0);
        chk("t5_late_done_busy", int'(busy), 0);

        // Asynchronous reset mid-WAIT
        press_digit(7); press_op(2); press_digit(4); press_eq(); cycle();
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_a", int'(a), 0);
        chk("t5_rst_b", int'(b), 0);
        chk("t5_rst_op", int'(op), 0);
        chk("t5_rst_start", int'(start), 0);
        chk("t5_rst_display", int'(display), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_error", int'(error), 0);
        model_zero();
        commit();
        cycle();
        reset = 1'b0;

        // Randomized key/AU traffic, including simultaneous strobes
        for (int i = 0; i < 4000; i++) begin
            digit_valid = ($urandom_range(0, 2) == 0);
            digit       = 4'($urandom_range(0, 15));
            op_valid    = ($urandom_range(0, 7) == 0);
            op_sel      = 3'($urandom_range(0, 7));
            eq_valid    = ($urandom_range(0, 7) == 0);
            clr_valid   = ($urandom_range(0, 59) == 0);
            au_done     = ($urandom_range(0, 3) == 0);
            au_result   = 8'($urandom_range(0, 255));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
